measure_buf: RTL and testbench
==============================

MEASURE_BUF -- requirements
Module: measure_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 16, result FIFO depth in 64-bit entries; power of two, 2..256.
REQ-002 SHALL have port clk_i  input  1  single clock for all logic.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port reg_wr_en_i  input  1  one-cycle strobe: new measurement result from the measure stage.
REQ-005 SHALL have port reg_wr_data_i  input  64  measurement result word, sampled when reg_wr_en_i=1.
REQ-006 SHALL have port clr_i  input  1  flush request from the register bank.
REQ-007 SHALL have port rd_en_i  input  1  one-cycle 32-bit read request from the register bank.
REQ-008 SHALL have port rd_data_o  output  32  registered read data.
REQ-009 SHALL have port rd_valid_o  output  1  one-cycle pulse qualifying rd_data_o.
REQ-010 SHALL have port count_o  output  $clog2(DEPTH)+1  number of stored entries.
REQ-011 SHALL have ports empty_o, full_o  output  1 each  count_o==0 and count_o==DEPTH respectively.
REQ-012 SHALL have port ovf_o  output  1  sticky: at least one result dropped.
REQ-013 SHALL have port drop_cnt_o  output  16  number of dropped results, saturating.

Function
REQ-014 SHALL store results in a circular buffer with wptr/rptr of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-015 SHALL accept a write when reg_wr_en_i=1 and (count<DEPTH or a pop occurs in the same cycle); the entry is visible in count_o/empty_o on the following cycle.
REQ-016 SHALL drop a write when reg_wr_en_i=1, count==DEPTH and no pop in that cycle; set ovf_o and increment drop_cnt_o, saturating at 16'hFFFF.
REQ-017 SHALL read each 64-bit entry as two 32-bit reads via a 2-state phase FSM: LO, HI.
REQ-018 In state LO with rd_en_i=1 and not empty, SHALL load rd_data_o<=head[31:0], with no pop, and go to HI.
REQ-019 In state HI with rd_en_i=1, SHALL load rd_data_o<=head[63:32], pop the head (rptr+1, count-1), and go to LO.
REQ-020 In state LO with rd_en_i=1 and empty, SHALL load rd_data_o<=32'h0 and stay in LO.
REQ-021 SHALL pulse rd_valid_o for exactly one cycle, the cycle after every rd_en_i; rd_en_i on consecutive cycles yields consecutive pulses.
REQ-022 SHALL handle a simultaneous accepted write and pop with count unchanged and both pointers advanced.
REQ-023 SHALL give clr_i priority over all other inputs: count=0, rptr=wptr=0, phase=LO, ovf_o=0, drop_cnt_o=0 on the next cycle.
REQ-024 A write coinciding with clr_i SHALL be discarded and not counted as a drop.
REQ-025 rd_en_i coinciding with clr_i SHALL still produce rd_valid_o with rd_data_o=32'h0.
REQ-026 SHALL drive all outputs from registers; there are no combinational input-to-output paths.

Reset
REQ-027 On rst_i=1 at a clk_i edge, SHALL set count_o=0, empty_o=1, full_o=0, ovf_o=0, drop_cnt_o=0, rd_data_o=0, rd_valid_o=0, phase=LO, pointers=0.
REQ-028 A reset mid-operation SHALL discard stored entries and any half-read entry.
REQ-029 SHALL not require clearing memory contents on reset.

Verification
REQ-030 Write 64'h1122334455667788, then rd_en_i twice -> rd_data_o=32'h55667788, then 32'h11223344, each with rd_valid_o; count_o goes 1->1->0.
REQ-031 Write DEPTH+3 distinct results with no reads -> full_o=1, ovf_o=1, drop_cnt_o=3; reads return the first DEPTH entries in order.
REQ-032 With the buffer full and in phase HI, issue a write and rd_en_i in the same cycle -> write accepted, count_o stays DEPTH, drop_cnt_o unchanged.
REQ-033 rd_en_i while empty -> rd_data_o=0, rd_valid_o pulses, phase stays LO, count_o=0.
REQ-034 Perform a low-word read, then clr_i together with a write -> count_o=0, ovf_o=0, phase=LO; the next rd_en_i returns 0.
REQ-035 Perform 2*DEPTH+5 write/read-pair cycles -> data order preserved across pointer wrap; assert rst_i mid-stream -> all REQ-027 values hold.

Source files
------------

// File: rtl/measure_buf.sv
// Result FIFO between the measure stage and the register bank: 64-bit entries
// are written whole and read back as two 32-bit halves (low word first).
module measure_buf #(
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     reg_wr_en_i,
  input  logic [63:0]              reg_wr_data_i,
  input  logic                     clr_i,
  input  logic                     rd_en_i,
  output logic [31:0]              rd_data_o,
  output logic                     rd_valid_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic                     ovf_o,
  output logic [15:0]              drop_cnt_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {LO, HI} phase_t;

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  phase_t        phase;
  logic          pop, push, drop, at_full;
  logic [CW-1:0] cnt_nxt;

  // HI is only reachable with a stored head, so a HI read always pops.
  always_comb begin
    at_full = (count_o == CW'(DEPTH));
    pop     = rd_en_i && (phase == HI) && !clr_i;
    push    = reg_wr_en_i && !clr_i && (!at_full || pop);
    drop    = reg_wr_en_i && !clr_i && at_full && !pop;
    cnt_nxt = count_o;
    if (push && !pop)      cnt_nxt = count_o + CW'(1);
    else if (pop && !push) cnt_nxt = count_o - CW'(1);
  end

  // Storage is deliberately not reset; pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (push) mem[wptr] <= reg_wr_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr       <= '0;
      rptr       <= '0;
      count_o    <= '0;
      empty_o    <= 1'b1;
      full_o     <= 1'b0;
      ovf_o      <= 1'b0;
      drop_cnt_o <= '0;
      rd_data_o  <= '0;
      rd_valid_o <= 1'b0;
      phase      <= LO;
    end else if (clr_i) begin
      wptr       <= '0;
      rptr       <= '0;
      count_o    <= '0;
      empty_o    <= 1'b1;
      full_o     <= 1'b0;
      ovf_o      <= 1'b0;
      drop_cnt_o <= '0;
      phase      <= LO;
      rd_valid_o <= rd_en_i;
      if (rd_en_i) rd_data_o <= '0;
    end else begin
      rd_valid_o <= rd_en_i;
      if (rd_en_i) begin
        case (phase)
          LO: begin
            if (count_o == '0) begin
              rd_data_o <= '0;
            end else begin
              rd_data_o <= mem[rptr][31:0];
              phase     <= HI;
            end
          end
          HI: begin
            rd_data_o <= mem[rptr][63:32];
            phase     <= LO;
          end
          default: phase <= LO;
        endcase
      end
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      count_o <= cnt_nxt;
      empty_o <= (cnt_nxt == '0);
      full_o  <= (cnt_nxt == CW'(DEPTH));
      if (drop) begin
        ovf_o <= 1'b1;
        if (drop_cnt_o != 16'hFFFF) drop_cnt_o <= drop_cnt_o + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_measure_buf.sv
// Directed bench for measure_buf: a vector table for basic read/write behaviour
// plus hand sequences for overflow, clear, pointer wrap and mid-stream reset.
module tb_measure_buf;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst, wr_en, clr, rd_en;
  logic [63:0]   wr_data;
  logic [31:0]   rd_data;
  logic          rd_valid, empty, full, ovf;
  logic [CW-1:0] count;
  logic [15:0]   drop_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  measure_buf #(.DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .reg_wr_en_i(wr_en), .reg_wr_data_i(wr_data),
    .clr_i(clr), .rd_en_i(rd_en), .rd_data_o(rd_data), .rd_valid_o(rd_valid),
    .count_o(count), .empty_o(empty), .full_o(full), .ovf_o(ovf),
    .drop_cnt_o(drop_cnt)
  );

  typedef struct {
    logic        wr;
    logic [63:0] d;
    logic        rd;
    logic        rv;
    logic [31:0] rdata;
    int          cnt;
    logic        e;
  } vec_t;

  vec_t vec [10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample #1 after the rising edge.
  task automatic cyc(input logic w, input logic [63:0] d, input logic c,
                     input logic r, input logic rs = 1'b0);
    @(negedge clk);
    wr_en = w; wr_data = d; clr = c; rd_en = r; rst = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_stat(input string nm, input int cnt, input logic f,
                          input logic o, input int dc);
    chk({nm, ".count"}, 64'(count), 64'(cnt));
    chk({nm, ".empty"}, 64'(empty), 64'(cnt == 0));
    chk({nm, ".full"},  64'(full),  64'(f));
    chk({nm, ".ovf"},   64'(ovf),   64'(o));
    chk({nm, ".drop"},  64'(drop_cnt), 64'(dc));
  endtask

  function automatic logic [63:0] wv(input int i);
    return {32'h1000_0000 + 32'(i), 32'h2000_0000 + 32'(i)};
  endfunction

  logic [63:0] q[$];
  logic [63:0] x, hd;

  initial begin
    wr_en = 0; wr_data = '0; clr = 0; rd_en = 0; rst = 1;
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("reset.rd_valid", 64'(rd_valid), 0);
    chk("reset.rd_data", 64'(rd_data), 0);
    chk_stat("reset", 0, 0, 0, 0);

    vec[0] = '{0, 64'h0,                  0, 0, 32'h0,        0, 1};
    vec[1] = '{0, 64'h0,                  1, 1, 32'h0,        0, 1};
    vec[2] = '{1, 64'h1122334455667788,   0, 0, 32'h0,        1, 0};
    vec[3] = '{0, 64'h0,                  1, 1, 32'h55667788, 1, 0};
    vec[4] = '{0, 64'h0,                  1, 1, 32'h11223344, 0, 1};
    vec[5] = '{1, 64'hA0A0A0A1B0B0B0B1,   1, 1, 32'h0,        1, 0};
    vec[6] = '{0, 64'h0,                  1, 1, 32'hB0B0B0B1, 1, 0};
    vec[7] = '{1, 64'hC0000002D0000003,   1, 1, 32'hA0A0A0A1, 1, 0};
    vec[8] = '{0, 64'h0,                  1, 1, 32'hD0000003, 1, 0};
    vec[9] = '{0, 64'h0,                  1, 1, 32'hC0000002, 0, 1};
    for (int i = 0; i < 10; i++) begin
      cyc(vec[i].wr, vec[i].d, 0, vec[i].rd);
      chk($sformatf("vec%0d.rd_valid", i), 64'(rd_valid), 64'(vec[i].rv));
      chk($sformatf("vec%0d.rd_data", i),  64'(rd_data),  64'(vec[i].rdata));
      chk($sformatf("vec%0d.count", i),    64'(count),    64'(vec[i].cnt));
      chk($sformatf("vec%0d.empty", i),    64'(empty),    64'(vec[i].e));
    end
    cyc(0, 0, 0, 0);
    chk("idle.rd_valid", 64'(rd_valid), 0);

    // Overflow: DEPTH+3 writes, no reads
    for (int i = 0; i < DEPTH + 3; i++) begin
      cyc(1, wv(i), 0, 0);
      if (i == DEPTH - 1) chk_stat("fill", DEPTH, 1, 0, 0);
    end
    cyc(0, 0, 0, 0);
    chk_stat("ovf", DEPTH, 1, 1, 3);

    // Full and in HI: simultaneous write + pop is accepted
    cyc(0, 0, 0, 1);
    chk("full_lo.rd_data", 64'(rd_data), 64'(wv(0)) & 64'hFFFF_FFFF);
    x = 64'hFEED_0001_BEEF_0002;
    cyc(1, x, 0, 1);
    chk("full_hi.rd_data", 64'(rd_data), wv(0) >> 32);
    chk_stat("full_hi", DEPTH, 1, 1, 3);
    for (int i = 1; i <= DEPTH; i++) begin
      hd = (i < DEPTH) ? wv(i) : x;
      cyc(0, 0, 0, 1);
      chk($sformatf("drain%0d.lo", i), 64'(rd_data), hd & 64'hFFFF_FFFF);
      cyc(0, 0, 0, 1);
      chk($sformatf("drain%0d.hi", i), 64'(rd_data), hd >> 32);
      chk($sformatf("drain%0d.rv", i), 64'(rd_valid), 1);
    end
    cyc(0, 0, 0, 0);
    chk_stat("drained", 0, 0, 1, 3);

    // Low-word read, then clear together with a write
    cyc(1, 64'h7777_6666_5555_4444, 0, 0);
    cyc(0, 0, 0, 1);
    chk("clr.pre_lo", 64'(rd_data), 64'h5555_4444);
    cyc(1, 64'h1234_5678_9ABC_DEF0, 1, 0);
    chk_stat("clr", 0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    chk("clr.next_rd", 64'(rd_data), 0);
    chk("clr.next_rv", 64'(rd_valid), 1);
    chk("clr.next_cnt", 64'(count), 0);

    // Read coinciding with clear still produces a zero pulse
    cyc(1, 64'hAAAA_BBBB_CCCC_DDDD, 0, 0);
    cyc(0, 0, 0, 1);
    chk("clrrd.lo", 64'(rd_data), 64'hCCCC_DDDD);
    cyc(0, 0, 1, 1);
    chk("clrrd.rv", 64'(rd_valid), 1);
    chk("clrrd.rd", 64'(rd_data), 0);
    chk("clrrd.cnt", 64'(count), 0);

    // Streaming across pointer wrap with two entries in flight
    q.delete();
    for (int i = 0; i < 2; i++) begin
      x = {32'h5000_0000 + 32'(i), 32'h6000_0000 + 32'(i)};
      cyc(1, x, 0, 0);
      q.push_back(x);
    end
    for (int i = 2; i < 2 * DEPTH + 7; i++) begin
      cyc(0, 0, 0, 1);
      chk($sformatf("wrap%0d.lo", i), 64'(rd_data), q[0] & 64'hFFFF_FFFF);
      x = {32'h5000_0000 + 32'(i), 32'h6000_0000 + 32'(i)};
      cyc(1, x, 0, 1);
      hd = q.pop_front();
      q.push_back(x);
      chk($sformatf("wrap%0d.hi", i), 64'(rd_data), hd >> 32);
      chk($sformatf("wrap%0d.cnt", i), 64'(count), 2);
    end

    // Reset after a half read discards everything
    cyc(0, 0, 0, 1);
    chk("prerst.lo", 64'(rd_data), q[0] & 64'hFFFF_FFFF);
    cyc(0, 0, 0, 0, 1);
    chk("rst.rd_valid", 64'(rd_valid), 0);
    chk("rst.rd_data", 64'(rd_data), 0);
    chk_stat("rst", 0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    chk("postrst.rd", 64'(rd_data), 0);
    chk("postrst.rv", 64'(rd_valid), 1);
    cyc(1, 64'h0BAD_F00D_0000_0001, 0, 0);
    cyc(0, 0, 0, 1);
    chk("postrst.lo", 64'(rd_data), 64'h0000_0001);
    cyc(0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
